// File: rtl/double_pkg.sv
`default_nettype none
// ============================================================================
// Module   : double_pkg
// Purpose  : Shared constants for blocks that move IEEE-754 doubles over
//            stb/ack channels: word width, sign bit position, +0.0 pattern,
//            the double_accum_master state encoding and a sign-flip helper.
// Revision : 1.0 - initial release
// ============================================================================
package double_pkg;

  localparam int          DOUBLE_W        = 64;
  localparam int          DOUBLE_SIGN     = 63;
  localparam logic [63:0] DOUBLE_POS_ZERO = 64'h0;

  // double_accum_master state encoding
  localparam int         ST_W         = 3;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_GET_FIRST = 3'd1;
  localparam logic [2:0] ST_GET_X     = 3'd2;
  localparam logic [2:0] ST_SEND_A    = 3'd3;
  localparam logic [2:0] ST_SEND_B    = 3'd4;
  localparam logic [2:0] ST_WAIT_Z    = 3'd5;
  localparam logic [2:0] ST_PUT_OUT   = 3'd6;

  // Negate a double by inverting only its sign bit; exponent and mantissa
  // pass through untouched so NaN/Inf payloads survive.
  function automatic logic [DOUBLE_W-1:0] double_neg(input logic [DOUBLE_W-1:0] v);
    logic [DOUBLE_W-1:0] r;
    r              = v;
    r[DOUBLE_SIGN] = ~v[DOUBLE_SIGN];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hs_send_slot.sv
`default_nettype none
// ============================================================================
// Module   : hs_send_slot
// Purpose  : Sender side of one stb/ack channel. A load captures data and
//            raises stb; data is held stable until the cycle stb and ack are
//            both high, at which edge stb drops.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            load, load_data - request to present load_data (ignored while stb)
//            ack             - receiver accept
//            data, stb       - channel data and valid
// Revision : 1.0 - initial release
// ============================================================================
module hs_send_slot
  import double_pkg::*;
#(
  parameter int W = DOUBLE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ack,
  output logic [W-1:0] data,
  output logic         stb
);

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      stb  <= 1'b0;
    end else if (stb && ack) begin
      stb  <= 1'b0;
    end else if (load && !stb) begin
      data <= load_data;
      stb  <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/double_accum_master.sv
`default_nettype none
// ============================================================================
// Module   : double_accum_master
// Purpose  : Sums a stream of cfg_len doubles by sequencing an external
//            stb/ack double adder (a first, then b, then collect z) and
//            returns the sum on the out channel. The first element is loaded
//            straight into the accumulator; len==0 yields +0.0.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            start, cfg_len, busy     - job control
//            in_data/in_stb/in_ack    - element stream from producer
//            add_a*, add_b*, add_z*   - adder operand and result channels
//            out_data/out_stb/out_ack - final sum to consumer
// Config   : DOUBLE_ACCUM_SUB_EN adds input 'sub' (latched at start); when 1,
//            elements 2..len are sign-flipped so the result is
//            first - sum(rest).
// Revision : 1.0 - initial release
// ============================================================================
module double_accum_master
  import double_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_len,
`ifdef DOUBLE_ACCUM_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  input  logic [63:0]      in_data,
  input  logic             in_stb,
  output logic             in_ack,
  output logic [63:0]      add_a,
  output logic             add_a_stb,
  input  logic             add_a_ack,
  output logic [63:0]      add_b,
  output logic             add_b_stb,
  input  logic             add_b_ack,
  input  logic [63:0]      add_z,
  input  logic             add_z_stb,
  output logic             add_z_ack,
  output logic [63:0]      out_data,
  output logic             out_stb,
  input  logic             out_ack
);

  logic [ST_W-1:0]     r_state;
  logic [CNT_W-1:0]    r_len;
  logic [CNT_W-1:0]    r_cnt;
  logic [DOUBLE_W-1:0] r_acc;
  logic [DOUBLE_W-1:0] r_x;
  logic                r_in_ack;
  logic                r_z_ack;

  logic [CNT_W-1:0]    w_cnt_inc;
  logic [DOUBLE_W-1:0] w_b_data;
  logic                w_a_load;
  logic                w_b_load;
  logic                w_out_load;

  assign w_cnt_inc = r_cnt + 1'b1;

`ifdef DOUBLE_ACCUM_SUB_EN
  logic r_sub;
  always_ff @(posedge clk) begin
    if (rst)
      r_sub <= 1'b0;
    else if (r_state == ST_IDLE && start)
      r_sub <= sub;
  end
  // r_x only ever holds elements 2..len, so the first element is never flipped.
  assign w_b_data = r_sub ? double_neg(r_x) : r_x;
`else
  assign w_b_data = r_x;
`endif

  // The slot suppresses reload while its own stb is high, and the FSM leaves
  // the state at the transfer edge, so each state issues exactly one transfer.
  assign w_a_load   = (r_state == ST_SEND_A);
  assign w_b_load   = (r_state == ST_SEND_B);
  assign w_out_load = (r_state == ST_PUT_OUT);

  assign busy      = (r_state != ST_IDLE);
  assign in_ack    = r_in_ack;
  assign add_z_ack = r_z_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_len    <= '0;
      r_cnt    <= '0;
      r_acc    <= DOUBLE_POS_ZERO;
      r_x      <= DOUBLE_POS_ZERO;
      r_in_ack <= 1'b0;
      r_z_ack  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_len <= cfg_len;
            r_cnt <= '0;
            if (cfg_len == '0) begin
              r_acc   <= DOUBLE_POS_ZERO;
              r_state <= ST_PUT_OUT;
            end else begin
              r_state <= ST_GET_FIRST;
            end
          end
        end
        ST_GET_FIRST: begin
          if (r_in_ack && in_stb) begin
            r_in_ack <= 1'b0;
            r_acc    <= in_data;
            r_cnt    <= {{(CNT_W-1){1'b0}}, 1'b1};
            r_state  <= (r_len == {{(CNT_W-1){1'b0}}, 1'b1}) ? ST_PUT_OUT : ST_GET_X;
          end else begin
            r_in_ack <= 1'b1;
          end
        end
        ST_GET_X: begin
          if (r_in_ack && in_stb) begin
            r_in_ack <= 1'b0;
            r_x      <= in_data;
            r_state  <= ST_SEND_A;
          end else begin
            r_in_ack <= 1'b1;
          end
        end
        ST_SEND_A: begin
          if (add_a_stb && add_a_ack)
            r_state <= ST_SEND_B;
        end
        ST_SEND_B: begin
          if (add_b_stb && add_b_ack)
            r_state <= ST_WAIT_Z;
        end
        ST_WAIT_Z: begin
          if (r_z_ack && add_z_stb) begin
            r_z_ack <= 1'b0;
            r_acc   <= add_z;
            r_cnt   <= w_cnt_inc;
            r_state <= (w_cnt_inc == r_len) ? ST_PUT_OUT : ST_GET_X;
          end else begin
            r_z_ack <= 1'b1;
          end
        end
        ST_PUT_OUT: begin
          if (out_stb && out_ack)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  hs_send_slot #(.W(DOUBLE_W)) u_slot_a (
    .clk       (clk),
    .rst       (rst),
    .load      (w_a_load),
    .load_data (r_acc),
    .ack       (add_a_ack),
    .data      (add_a),
    .stb       (add_a_stb)
  );

  hs_send_slot #(.W(DOUBLE_W)) u_slot_b (
    .clk       (clk),
    .rst       (rst),
    .load      (w_b_load),
    .load_data (w_b_data),
    .ack       (add_b_ack),
    .data      (add_b),
    .stb       (add_b_stb)
  );

  hs_send_slot #(.W(DOUBLE_W)) u_slot_out (
    .clk       (clk),
    .rst       (rst),
    .load      (w_out_load),
    .load_data (r_acc),
    .ack       (out_ack),
    .data      (out_data),
    .stb       (out_stb)
  );

endmodule
`default_nettype wire

// File: tb/tb_double_accum_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_double_accum_master
// Purpose  : Directed self-checking bench for double_accum_master with a
//            behavioural stb/ack double adder, a queue-fed producer and a
//            bench-driven consumer. Define DOUBLE_ACCUM_SUB_EN to cover 'sub'.
// Revision : 1.0 - initial release
// ============================================================================
module tb_double_accum_master;

  localparam logic [63:0] D1 = 64'h3FF0000000000000;
  localparam logic [63:0] D2 = 64'h4000000000000000;
  localparam logic [63:0] D3 = 64'h4008000000000000;
  localparam logic [63:0] D6 = 64'h4018000000000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] cfg_len;
`ifdef DOUBLE_ACCUM_SUB_EN
  logic        sub;
`endif
  logic        busy;
  logic [63:0] in_data;
  logic        in_stb;
  logic        in_ack;
  logic [63:0] add_a;
  logic        add_a_stb;
  logic        add_a_ack;
  logic [63:0] add_b;
  logic        add_b_stb;
  logic        add_b_ack;
  logic [63:0] add_z;
  logic        add_z_stb;
  logic        add_z_ack;
  logic [63:0] out_data;
  logic        out_stb;
  logic        out_ack;

  always #5 clk = ~clk;

  double_accum_master #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_len   (cfg_len),
`ifdef DOUBLE_ACCUM_SUB_EN
    .sub       (sub),
`endif
    .busy      (busy),
    .in_data   (in_data),
    .in_stb    (in_stb),
    .in_ack    (in_ack),
    .add_a     (add_a),
    .add_a_stb (add_a_stb),
    .add_a_ack (add_a_ack),
    .add_b     (add_b),
    .add_b_stb (add_b_stb),
    .add_b_ack (add_b_ack),
    .add_z     (add_z),
    .add_z_stb (add_z_stb),
    .add_z_ack (add_z_ack),
    .out_data  (out_data),
    .out_stb   (out_stb),
    .out_ack   (out_ack)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- producer: presents queued elements ----------------
  logic [63:0] prod_q[$];
  bit          prod_pend;

  initial begin
    in_stb    = 1'b0;
    in_data   = 64'h0;
    prod_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prod_q.delete();
        in_stb    = 1'b0;
        prod_pend = 1'b0;
      end else begin
        if (prod_pend) begin
          void'(prod_q.pop_front());
          in_stb    = 1'b0;
          prod_pend = 1'b0;
        end
        if (!in_stb && prod_q.size() > 0) begin
          in_data = prod_q[0];
          in_stb  = 1'b1;
        end
        if (in_stb && in_ack) prod_pend = 1'b1;
      end
    end
  end

  // ---------------- behavioural adder: get_a, get_b, put_z ----------------
  int          ast;
  int          z_cnt;
  int          order_err;
  bit          z_offered;
  logic [63:0] ma, mb;

  initial begin
    ast = 0; z_cnt = 0; order_err = 0; z_offered = 1'b0;
    add_a_ack = 1'b0; add_b_ack = 1'b0; add_z_stb = 1'b0; add_z = 64'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ast = 0; add_a_ack = 1'b0; add_b_ack = 1'b0; add_z_stb = 1'b0;
      end else begin
        if (add_b_stb && ast < 2) order_err++;
        case (ast)
          0: if (add_a_stb) begin ma = add_a; add_a_ack = 1'b1; ast = 1; end
          1: begin add_a_ack = 1'b0; ast = 2; end
          2: if (add_b_stb) begin mb = add_b; add_b_ack = 1'b1; ast = 3; end
          3: begin
               add_b_ack = 1'b0;
               add_z     = $realtobits($bitstoreal(ma) + $bitstoreal(mb));
               add_z_stb = 1'b1;
               z_offered = 1'b1;
               ast       = 4;
             end
          4: if (add_z_ack) ast = 5;
          default: begin add_z_stb = 1'b0; z_cnt++; ast = 0; end
        endcase
      end
    end
  end

  // ---------------- activity monitor ----------------
  int a_stb_seen = 0;
  int in_ack_seen = 0;
  always @(negedge clk) begin
    if (add_a_stb) a_stb_seen++;
    if (in_ack)    in_ack_seen++;
  end

  // ---------------- helpers ----------------
  task automatic do_start(input logic [15:0] len, input bit sub_v);
    @(negedge clk);
    cfg_len = len;
    start   = 1'b1;
`ifdef DOUBLE_ACCUM_SUB_EN
    sub     = sub_v;
`else
    if (sub_v) $display("note: sub requested without DOUBLE_ACCUM_SUB_EN");
`endif
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_out(input int max, output int waited, output bit ok);
    ok = 1'b0;
    for (waited = 0; waited < max; waited++) begin
      if (out_stb) begin ok = 1'b1; return; end
      @(negedge clk);
    end
  endtask

  task automatic take_out(input string tag);
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
    check_eq({tag, "_busy_after"}, busy, 1'b0);
  endtask

  task automatic reduce(input string tag, input logic [15:0] len, input bit sub_v,
                        input logic [63:0] expect_v);
    int w; bit ok;
    do_start(len, sub_v);
    wait_out(300, w, ok);
    check_eq({tag, "_out_seen"}, ok, 1'b1);
    check_eq({tag, "_out_data"}, out_data, expect_v);
    if (ok) take_out(tag);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w; bit ok; int z0; int bad; logic [63:0] saved;
    rst = 1'b1; start = 1'b0; cfg_len = '0; out_ack = 1'b0;
`ifdef DOUBLE_ACCUM_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_eq("reset_ctrl", {busy, in_ack, add_a_stb, add_b_stb, add_z_ack, out_stb}, 6'b0);
    check_eq("reset_out_data", out_data, 64'h0);
    check_eq("reset_add_a", add_a, 64'h0);
    check_eq("reset_add_b", add_b, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // 1 + 2 + 3 = 6, exactly two adder transactions
    z0 = z_cnt;
    prod_q.push_back(D1); prod_q.push_back(D2); prod_q.push_back(D3);
    reduce("len3", 16'd3, 1'b0, D6);
    check_eq("len3_adds", z_cnt - z0, 2);

    // single element bypasses the adder
    a_stb_seen = 0; z0 = z_cnt;
    prod_q.push_back(D2);
    reduce("len1", 16'd1, 1'b0, D2);
    check_eq("len1_no_a_stb", a_stb_seen, 0);
    check_eq("len1_adds", z_cnt - z0, 0);

    // empty reduction returns +0.0 quickly without touching the producer
    in_ack_seen = 0;
    do_start(16'd0, 1'b0);
    wait_out(2, w, ok);
    check_eq("len0_out_fast", ok, 1'b1);
    check_eq("len0_out_data", out_data, 64'h0);
    if (ok) take_out("len0");
    check_eq("len0_no_in_ack", in_ack_seen, 0);

    // consumer stall: output held, busy held, start ignored
    prod_q.push_back(D1); prod_q.push_back(D2); prod_q.push_back(D3);
    do_start(16'd3, 1'b0);
    wait_out(300, w, ok);
    check_eq("stall_out_seen", ok, 1'b1);
    saved = out_data;
    bad   = 0;
    for (int i = 0; i < 10; i++) begin
      if (!out_stb || !busy || out_data !== saved) bad++;
      if (i == 3) begin cfg_len = 16'd0; start = 1'b1; end
      if (i == 4) start = 1'b0;
      @(negedge clk);
    end
    check_eq("stall_stable", bad, 0);
    check_eq("stall_out_data", saved, D6);
    take_out("stall");
    repeat (4) @(negedge clk);
    check_eq("stall_start_ignored", {busy, out_stb}, 2'b00);

`ifdef DOUBLE_ACCUM_SUB_EN
    // 6 - 2 - 3 = 1
    prod_q.push_back(D6); prod_q.push_back(D2); prod_q.push_back(D3);
    reduce("sub", 16'd3, 1'b1, D1);
`endif

    // reset while waiting for the first adder result
    z_offered = 1'b0;
    prod_q.push_back(D1); prod_q.push_back(D2); prod_q.push_back(D3);
    do_start(16'd3, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (z_offered) begin ok = 1'b1; break; end
    end
    check_eq("rst_reached_wait_z", ok, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_ctrl", {busy, in_ack, add_a_stb, add_b_stb, add_z_ack, out_stb}, 6'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    prod_q.push_back(D1); prod_q.push_back(D1);
    reduce("after_rst", 16'd2, 1'b0, D2);

    check_eq("b_never_before_a", order_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
